// File: rtl/multicycle_control_pkg.sv
// Shared types and encodings for the multi-cycle control path.
// State enum, opcodes, datapath mux selects, ALU ops and trap causes.
package multicycle_control_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BRANCH,
    S_JAL,
    S_TRAP
  } state_e;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

endpackage

// File: rtl/multicycle_control_alu_decoder.sv
// Combinational funct3/funct7 to ALU operation decode.
// Flags funct3 values the datapath cannot execute.
module alu_decoder
  import multicycle_control_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       is_rtype,
  output logic [2:0] alu_control,
  output logic       illegal
);

  // sub only exists for R-type; addi ignores instr[30]
  always_comb begin
    alu_control = ALU_ADD;
    illegal     = 1'b0;
    unique case (funct3)
      3'b000: alu_control = (is_rtype && funct7b5) ? ALU_SUB : ALU_ADD;
      3'b010: alu_control = ALU_SLT;
      3'b110: alu_control = ALU_OR;
      3'b111: alu_control = ALU_AND;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle RV32I-subset control FSM over one shared memory port.
// Stalls on mem_ready with a bounded wait; traps on illegal ops/timeout.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int ALUCTRL_W   = 3,
  parameter int MEM_TIMEOUT = 16,
  parameter int EN_BNE      = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [6:0]           op,
  input  logic [2:0]           funct3,
  input  logic                 funct7b5,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 mem_req,
  output logic                 mem_write,
  output logic                 adr_src,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic                 reg_write,
  output logic [1:0]           alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [1:0]           result_src,
  output logic [1:0]           imm_src,
  output logic [ALUCTRL_W-1:0] alu_control,
  output logic                 instr_done,
  output logic                 trap,
  output logic [1:0]           trap_cause
);

  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [7:0] wait_q, wait_d;
  logic [1:0] cause_q, cause_d;

  logic       req_s, wr_s, ir_s, pcu_s;
  logic       br_s, rw_s, done_s, trap_s;
  logic [2:0] alu_s, dec_alu;
  logic       alu_ill, taken, in_wait, wait_hit;
  logic       is_mem, is_r, is_i, is_br, is_jal;
  logic       br_ok, bad_op;

  alu_decoder u_alu_dec (
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .is_rtype    (is_r),
    .alu_control (dec_alu),
    .illegal     (alu_ill)
  );

  assign is_mem = (op == OP_LW) || (op == OP_SW);
  assign is_r   = (op == OP_R);
  assign is_i   = (op == OP_I);
  assign is_br  = (op == OP_BR);
  assign is_jal = (op == OP_JAL);
  assign br_ok  = (funct3 == 3'b000) ||
                  ((funct3 == 3'b001) && (EN_BNE != 0));
  assign bad_op = !(is_mem || is_jal ||
                    ((is_r || is_i) && !alu_ill) ||
                    (is_br && br_ok));

  assign taken    = funct3[0] ? ~zero : zero;
  assign in_wait  = (state_q == S_FETCH) ||
                    (state_q == S_MEMRD) ||
                    (state_q == S_MEMWR);
  assign wait_hit = (wait_q == WAIT_LAST) && !mem_ready;

  // State, wait counter and trap cause registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      wait_q  <= 8'd0;
      cause_q <= CAUSE_NONE;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      cause_q <= cause_d;
    end
  end

  // Stall cycles accumulate only while parked in a memory state
  always_comb begin
    wait_d = wait_q;
    if (state_d != state_q) begin
      wait_d = 8'd0;
    end else if (in_wait && !mem_ready) begin
      wait_d = wait_q + 8'd1;
    end
  end

  // Next state and Moore-decoded controls
  always_comb begin
    state_d    = state_q;
    cause_d    = cause_q;
    req_s      = 1'b0;
    wr_s       = 1'b0;
    ir_s       = 1'b0;
    pcu_s      = 1'b0;
    br_s       = 1'b0;
    rw_s       = 1'b0;
    done_s     = 1'b0;
    trap_s     = 1'b0;
    adr_src    = 1'b0;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RS2;
    result_src = RES_ALUOUT;
    imm_src    = IMM_I;
    alu_s      = ALU_ADD;
    unique case (state_q)
      S_FETCH: begin
        req_s      = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURES;
        if (mem_ready) begin
          ir_s    = 1'b1;
          pcu_s   = 1'b1;
          state_d = S_DECODE;
        end else if (wait_hit) begin
          state_d = S_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        imm_src   = IMM_B;
        if (bad_op) begin
          state_d = S_TRAP;
          cause_d = CAUSE_ILLEGAL;
        end else begin
          unique case (1'b1)
            is_mem:  state_d = S_MEMADR;
            is_r:    state_d = S_EXECR;
            is_i:    state_d = S_EXECI;
            is_br:   state_d = S_BRANCH;
            is_jal:  state_d = S_JAL;
            default: state_d = S_TRAP;
          endcase
        end
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        if (op == OP_SW) begin
          imm_src = IMM_S;
          state_d = S_MEMWR;
        end else begin
          imm_src = IMM_I;
          state_d = S_MEMRD;
        end
      end
      S_MEMRD: begin
        req_s   = 1'b1;
        adr_src = 1'b1;
        if (mem_ready) begin
          state_d = S_MEMWB;
        end else if (wait_hit) begin
          state_d = S_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      S_MEMWB: begin
        result_src = RES_DATA;
        rw_s       = 1'b1;
        done_s     = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        req_s   = 1'b1;
        wr_s    = 1'b1;
        adr_src = 1'b1;
        if (mem_ready) begin
          done_s  = 1'b1;
          state_d = S_FETCH;
        end else if (wait_hit) begin
          state_d = S_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      S_EXECR: begin
        alu_src_a = SRCA_RS1;
        alu_s     = dec_alu;
        state_d   = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        alu_s     = dec_alu;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        rw_s    = 1'b1;
        done_s  = 1'b1;
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = SRCA_RS1;
        alu_s     = ALU_SUB;
        br_s      = 1'b1;
        done_s    = 1'b1;
        state_d   = S_FETCH;
      end
      S_JAL: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_FOUR;
        pcu_s     = 1'b1;
        state_d   = S_ALUWB;
      end
      S_TRAP: begin
        trap_s = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Reset overrides every enable in the cycle it is asserted
  always_comb begin
    mem_req     = req_s & ~rst;
    mem_write   = wr_s & ~rst;
    ir_write    = ir_s & ~rst;
    pc_write    = (pcu_s | (br_s & taken)) & ~rst;
    reg_write   = rw_s & ~rst;
    instr_done  = done_s & ~rst;
    trap        = trap_s & ~rst;
    trap_cause  = rst ? CAUSE_NONE : cause_q;
    alu_control = ALUCTRL_W'(alu_s);
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: phase-level model checked every cycle,
// plus directed instruction runs with literal cycle/flag expectations.
module tb_multicycle_control;

  localparam int TO = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] op = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic       funct7b5 = 1'b0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, mem_write, adr_src, ir_write;
  logic       pc_write, reg_write, instr_done, trap;
  logic [1:0] alu_src_a, alu_src_b, result_src, imm_src, trap_cause;
  logic [2:0] alu_control;

  int vectors = 0;
  int errs = 0;

  multicycle_control #(
    .ALUCTRL_W   (3),
    .MEM_TIMEOUT (TO),
    .EN_BNE      (1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .op          (op),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .zero        (zero),
    .mem_ready   (mem_ready),
    .mem_req     (mem_req),
    .mem_write   (mem_write),
    .adr_src     (adr_src),
    .ir_write    (ir_write),
    .pc_write    (pc_write),
    .reg_write   (reg_write),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .result_src  (result_src),
    .imm_src     (imm_src),
    .alu_control (alu_control),
    .instr_done  (instr_done),
    .trap        (trap),
    .trap_cause  (trap_cause)
  );

  always #5 clk = ~clk;

  // memory: answers after N cycles of an outstanding request
  int fetch_delay = 0;
  int data_delay = 0;
  int req_cnt = 0;
  always @(posedge clk) begin
    #2;
    if (mem_req) begin
      if (req_cnt >= (adr_src ? data_delay : fetch_delay)) begin
        mem_ready = 1'b1;
        req_cnt = 0;
      end else begin
        mem_ready = 1'b0;
        req_cnt++;
      end
    end else begin
      mem_ready = 1'b0;
      req_cnt = 0;
    end
  end

  function automatic logic [2:0] m_alu(input logic [2:0] f3,
                                       input logic f7, input logic isr);
    case (f3)
      3'd0: return (isr && f7) ? 3'd1 : 3'd0;
      3'd2: return 3'd5;
      3'd6: return 3'd3;
      default: return 3'd2;
    endcase
  endfunction

  // ---------------- phase-level reference model ----------------
  string ph = "fetch";
  string nph;
  int waited = 0;
  logic [1:0] mcause = 2'd0;
  logic e_req, e_wr, e_ir, e_pc, e_rw, e_done, e_trap;
  logic [1:0] e_cause, e_a, e_b, e_res, e_imm;
  logic e_adr;
  logic [2:0] e_alu;
  logic c_adr, c_a, c_b, c_res, c_imm, c_alu, bad;

  always @(negedge clk) begin
    e_req = 0; e_wr = 0; e_ir = 0; e_pc = 0;
    e_rw = 0; e_done = 0; e_trap = 0; e_cause = 0;
    c_adr = 0; c_a = 0; c_b = 0; c_res = 0; c_imm = 0; c_alu = 0;
    e_adr = 0; e_a = 0; e_b = 0; e_res = 0; e_imm = 0; e_alu = 0;
    nph = ph;
    if (rst) begin
      nph = "fetch";
      mcause = 0;
    end else if (ph == "fetch") begin
      e_req = 1; c_adr = 1; e_adr = 0; c_a = 1; e_a = 0;
      c_b = 1; e_b = 2; c_alu = 1; e_alu = 0; c_res = 1; e_res = 2;
      e_ir = mem_ready; e_pc = mem_ready;
      if (mem_ready) nph = "decode";
      else if (waited + 1 >= TO) begin nph = "trap"; mcause = 2; end
    end else if (ph == "decode") begin
      c_a = 1; e_a = 1; c_b = 1; e_b = 1; c_imm = 1; e_imm = 2;
      case (op)
        7'b0000011, 7'b0100011: nph = "memadr";
        7'b0110011: nph = (funct3 inside {0, 2, 6, 7}) ? "execr" : "bad";
        7'b0010011: nph = (funct3 inside {0, 2, 6, 7}) ? "execi" : "bad";
        7'b1100011: nph = (funct3 <= 3'd1) ? "branch" : "bad";
        7'b1101111: nph = "jal";
        default: nph = "bad";
      endcase
      if (nph == "bad") begin nph = "trap"; mcause = 1; end
    end else if (ph == "memadr") begin
      c_a = 1; e_a = 2; c_b = 1; e_b = 1; c_alu = 1; e_alu = 0;
      c_imm = 1;
      e_imm = (op == 7'b0100011) ? 2'd1 : 2'd0;
      nph = (op == 7'b0100011) ? "memwr" : "memrd";
    end else if (ph == "memrd" || ph == "memwr") begin
      e_req = 1; c_adr = 1; e_adr = 1; c_res = 1; e_res = 0;
      e_wr = (ph == "memwr");
      e_done = (ph == "memwr") && mem_ready;
      if (mem_ready) nph = (ph == "memwr") ? "fetch" : "memwb";
      else if (waited + 1 >= TO) begin nph = "trap"; mcause = 2; end
    end else if (ph == "memwb") begin
      c_res = 1; e_res = 1; e_rw = 1; e_done = 1; nph = "fetch";
    end else if (ph == "execr" || ph == "execi") begin
      c_a = 1; e_a = 2; c_b = 1; c_alu = 1;
      e_b = (ph == "execi") ? 2'd1 : 2'd0;
      c_imm = (ph == "execi");
      e_alu = m_alu(funct3, funct7b5, ph == "execr");
      nph = "aluwb";
    end else if (ph == "aluwb") begin
      c_res = 1; e_res = 0; e_rw = 1; e_done = 1; nph = "fetch";
    end else if (ph == "branch") begin
      c_a = 1; e_a = 2; c_b = 1; e_b = 0; c_alu = 1; e_alu = 1;
      c_res = 1; e_res = 0; e_done = 1;
      e_pc = (funct3 == 3'd0) ? zero : !zero;
      nph = "fetch";
    end else if (ph == "jal") begin
      c_a = 1; e_a = 1; c_b = 1; e_b = 2; c_alu = 1; e_alu = 0;
      c_res = 1; e_res = 0; e_pc = 1; nph = "aluwb";
    end else begin
      e_trap = 1; e_cause = mcause;
    end
    bad = ({mem_req, mem_write, ir_write, pc_write, reg_write,
            instr_done, trap, trap_cause} !==
           {e_req, e_wr, e_ir, e_pc, e_rw, e_done, e_trap, e_cause});
    bad |= c_adr && (adr_src !== e_adr);
    bad |= c_a && (alu_src_a !== e_a);
    bad |= c_b && (alu_src_b !== e_b);
    bad |= c_res && (result_src !== e_res);
    bad |= c_imm && (imm_src !== e_imm);
    bad |= c_alu && (alu_control !== e_alu);
    vectors++;
    if (bad) begin
      errs++;
      $display("FAIL cycle[%s] t=%0t got req%b wr%b ir%b pc%b rw%b dn%b tr%b c%b adr%b a%b b%b res%b imm%b alu%b | want req%b wr%b ir%b pc%b rw%b dn%b tr%b c%b adr%b a%b b%b res%b imm%b alu%b",
               ph, $time, mem_req, mem_write, ir_write, pc_write,
               reg_write, instr_done, trap, trap_cause, adr_src,
               alu_src_a, alu_src_b, result_src, imm_src, alu_control,
               e_req, e_wr, e_ir, e_pc, e_rw, e_done, e_trap, e_cause,
               e_adr, e_a, e_b, e_res, e_imm, e_alu);
    end
    if (rst || nph != ph) waited = 0;
    else if (!mem_ready) waited++;
    ph = nph;
  end

  // ---------------- directed stimulus ----------------
  task automatic check(input string name, input int got, input int want);
    vectors++;
    if (got != want) begin
      errs++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  int r_cyc, r_reqd, r_rdy;
  logic r_pcw, r_rw, r_trap;
  logic [1:0] r_res, r_cause;
  logic [2:0] r_alu3;

  // called at the start of a FETCH cycle; returns at the next one
  task automatic run(input logic [6:0] o, input logic [2:0] f3,
                     input logic f7, input logic z,
                     input int fd, input int dd);
    op = o; funct3 = f3; funct7b5 = f7; zero = z;
    fetch_delay = fd; data_delay = dd;
    r_cyc = 0; r_reqd = 0; r_rdy = 0; r_alu3 = 3'd7;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      r_cyc++;
      if (mem_req && adr_src) r_reqd++;
      if (mem_req && adr_src && mem_ready) r_rdy = r_cyc;
      if (r_cyc == 3) r_alu3 = alu_control;
      r_pcw = pc_write; r_rw = reg_write; r_res = result_src;
      r_trap = trap; r_cause = trap_cause;
      if (instr_done || trap) break;
    end
    @(posedge clk); #1;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    @(negedge clk);
    check("rst_enables", {mem_req, mem_write, reg_write, pc_write}, 0);
    check("rst_trap", {trap, trap_cause}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  int en_cnt;

  initial begin
    @(negedge clk);
    check("reset_req", mem_req, 0);
    check("reset_cause", trap_cause, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    run(7'b0110011, 3'b000, 1'b0, 1'b0, 0, 0);
    check("add_cycles", r_cyc, 4);
    check("add_alu", r_alu3, 0);
    check("add_regwrite", r_rw, 1);
    run(7'b0110011, 3'b000, 1'b1, 1'b0, 0, 0);
    check("sub_alu", r_alu3, 1);
    run(7'b0010011, 3'b000, 1'b1, 1'b0, 0, 0);
    check("addi_f7_alu", r_alu3, 0);
    run(7'b0110011, 3'b010, 1'b0, 1'b0, 0, 0);
    check("slt_alu", r_alu3, 5);
    run(7'b0010011, 3'b110, 1'b0, 1'b0, 0, 0);
    check("ori_alu", r_alu3, 3);
    run(7'b0010011, 3'b111, 1'b0, 1'b0, 0, 0);
    check("andi_alu", r_alu3, 2);

    run(7'b0000011, 3'b010, 1'b0, 1'b0, 0, 3);
    check("lw_req_cycles", r_reqd, 4);
    check("lw_mem_done_cycle", r_rdy, 7);
    check("lw_retire_cycle", r_cyc, 8);
    check("lw_result_src", r_res, 1);
    run(7'b0100011, 3'b010, 1'b0, 1'b0, 0, 1);
    check("sw_cycles", r_cyc, 5);

    run(7'b1100011, 3'b000, 1'b0, 1'b1, 0, 0);
    check("beq_z1_pcw", r_pcw, 1);
    check("beq_cycles", r_cyc, 3);
    run(7'b1100011, 3'b001, 1'b0, 1'b1, 0, 0);
    check("bne_z1_pcw", r_pcw, 0);
    run(7'b1100011, 3'b001, 1'b0, 1'b0, 0, 0);
    check("bne_z0_pcw", r_pcw, 1);
    run(7'b1100011, 3'b000, 1'b0, 1'b0, 0, 0);
    check("beq_z0_pcw", r_pcw, 0);
    run(7'b1101111, 3'b000, 1'b0, 1'b0, 0, 0);
    check("jal_cycles", r_cyc, 4);
    check("jal_regwrite", r_rw, 1);

    run(7'b0110011, 3'b000, 1'b0, 1'b0, 3, 0);
    check("late_fetch_cycles", r_cyc, 7);
    check("late_fetch_trap", r_trap, 0);

    run(7'b0001111, 3'b000, 1'b0, 1'b0, 0, 0);
    check("illop_trap_cycle", r_cyc, 3);
    check("illop_cause", r_cause, 1);
    en_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (mem_req || mem_write || ir_write || pc_write ||
          reg_write || instr_done) en_cnt++;
    end
    check("trap_enables_idle", en_cnt, 0);
    check("trap_sticky", trap, 1);
    @(posedge clk); #1;
    pulse_rst();

    run(7'b0110011, 3'b001, 1'b0, 1'b0, 0, 0);
    check("illfunct3_cycle", r_cyc, 3);
    check("illfunct3_cause", r_cause, 1);
    pulse_rst();

    run(7'b0110011, 3'b000, 1'b0, 1'b0, 255, 0);
    check("timeout_trap_cycle", r_cyc, TO + 1);
    check("timeout_cause", r_cause, 2);
    pulse_rst();

    op = 7'b0100011; funct3 = 3'b010;
    fetch_delay = 0; data_delay = 255;
    repeat (4) @(negedge clk);
    check("memwr_write", mem_write, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("rst_in_memwr_write", mem_write, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    run(7'b0110011, 3'b000, 1'b0, 1'b0, 0, 0);
    check("after_rst_cycles", r_cyc, 4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, errs %0d", errs);
    $fatal(1);
  end

endmodule
